// File: rtl/motor_ramp_ctrl.sv
// Slews H-bridge duty toward a commanded (dir, duty) target at a fixed step rate,
// inserting a zero-duty dead time on direction reversal; estop forces duty to zero.
module motor_ramp_ctrl #(
  parameter int DUTY_W      = 8,
  parameter int STEP_DIV    = 256,
  parameter int STEP_SIZE   = 1,
  parameter int DEAD_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic              drv_en,
  output logic              busy,
  output logic              at_target
);

  localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DC_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(STEP_DIV - 1);
  localparam logic [DC_W-1:0]   DC_LAST = DC_W'(DEAD_CYCLES - 1);
  localparam logic [DUTY_W:0]   STEP_W1 = (DUTY_W + 1)'(STEP_SIZE);
  localparam logic [DUTY_W-1:0] STEP_N  = DUTY_W'(STEP_SIZE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RAMP  = 2'd1;
  localparam logic [1:0] DEAD  = 2'd2;
  localparam logic [1:0] ESTOP = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic              dir_nxt;
  logic [DUTY_W-1:0] target_duty, target_duty_nxt;
  logic              target_dir, target_dir_nxt;
  logic [PS_W-1:0]   prescaler, prescaler_nxt;
  logic [DC_W-1:0]   dead_cnt, dead_cnt_nxt;

  logic              accept;
  logic              tick;
  logic              eff_dir;
  logic [DUTY_W-1:0] eff_duty;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_lim;
  logic [DUTY_W-1:0] toward_target;
  logic [DUTY_W-1:0] toward_zero;

  assign cmd_ready = (state != ESTOP) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (prescaler == PS_LAST);

  // A command landing on the same edge as a tick steers that tick, so the
  // IDLE-exit check never compares against a stale target.
  assign eff_dir  = accept ? cmd_dir  : target_dir;
  assign eff_duty = accept ? cmd_duty : target_duty;

  // One extra bit keeps duty +/- STEP from wrapping before the clamp.
  assign up_sum = {1'b0, duty} + STEP_W1;
  assign dn_lim = {1'b0, eff_duty} + STEP_W1;

  always_comb begin
    toward_target = eff_duty;
    if (duty < eff_duty) begin
      toward_target = (up_sum >= {1'b0, eff_duty}) ? eff_duty : up_sum[DUTY_W-1:0];
    end else begin
      toward_target = ({1'b0, duty} >= dn_lim) ? (duty - STEP_N) : eff_duty;
    end
  end

  assign toward_zero = ({1'b0, duty} >= STEP_W1) ? (duty - STEP_N) : '0;

  always_comb begin
    state_nxt       = state;
    duty_nxt        = duty;
    dir_nxt         = dir;
    target_duty_nxt = target_duty;
    target_dir_nxt  = target_dir;
    prescaler_nxt   = prescaler;
    dead_cnt_nxt    = dead_cnt;

    if (estop) begin
      duty_nxt        = '0;
      target_duty_nxt = '0;
      state_nxt       = ESTOP;
    end else begin
      if (accept) begin
        target_dir_nxt  = cmd_dir;
        target_duty_nxt = cmd_duty;
      end

      case (state)
        IDLE: begin
          if (accept && ((cmd_dir != dir) || (cmd_duty != duty))) begin
            state_nxt     = RAMP;
            prescaler_nxt = '0;
          end
        end

        RAMP: begin
          prescaler_nxt = tick ? '0 : (prescaler + PS_W'(1));
          if (tick) begin
            duty_nxt = (dir == eff_dir) ? toward_target : toward_zero;
          end
          // Reversal reaching zero enters the dwell on the very edge duty hits 0.
          if ((dir != eff_dir) && (duty_nxt == '0)) begin
            state_nxt    = DEAD;
            dead_cnt_nxt = '0;
          end else if (tick && (dir == eff_dir) && (duty_nxt == eff_duty)) begin
            state_nxt = IDLE;
          end
        end

        DEAD: begin
          duty_nxt = '0;
          if (dead_cnt == DC_LAST) begin
            dir_nxt       = eff_dir;
            prescaler_nxt = '0;
            state_nxt     = RAMP;
          end else begin
            dead_cnt_nxt = dead_cnt + DC_W'(1);
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      duty        <= '0;
      dir         <= 1'b0;
      target_duty <= '0;
      target_dir  <= 1'b0;
      prescaler   <= '0;
      dead_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      duty        <= duty_nxt;
      dir         <= dir_nxt;
      target_duty <= target_duty_nxt;
      target_dir  <= target_dir_nxt;
      prescaler   <= prescaler_nxt;
      dead_cnt    <= dead_cnt_nxt;
    end
  end

  assign drv_en    = (duty != '0);
  assign busy      = (state != IDLE);
  assign at_target = (state == IDLE) && (duty == target_duty) && (dir == target_dir);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with a cycle-indexed scoreboard of expected outputs.
module tb_motor_ramp_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_duty;
  logic       estop;
  logic [7:0] duty;
  logic       dir;
  logic       drv_en;
  logic       busy;
  logic       at_target;

  motor_ramp_ctrl #(
    .DUTY_W(8), .STEP_DIV(4), .STEP_SIZE(16), .DEAD_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
    .estop(estop),
    .duty(duty), .dir(dir), .drv_en(drv_en),
    .busy(busy), .at_target(at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [12:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [12:0] outs;

  assign outs = {duty, dir, drv_en, busy, at_target, cmd_ready};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] pk(input logic [7:0] d, input logic dr, input logic b,
                                     input logic at, input logic rdy);
    return {d, dr, (d != 8'd0), b, at, rdy};
  endfunction

  task automatic cmp(input string tag, input logic [12:0] obs, input logic [12:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: got duty=%0d dir=%b drv_en=%b busy=%b at_target=%b cmd_ready=%b; want duty=%0d dir=%b drv_en=%b busy=%b at_target=%b cmd_ready=%b",
             tag, obs[12:5], obs[4], obs[3], obs[2], obs[1], obs[0],
             want[12:5], want[4], want[3], want[2], want[1], want[0]);
    end
  endtask

  // Pop every expectation due after the most recent rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      cmp(e.tag, outs, e.val);
    end
  end

  task automatic expect_at(input int c, input string tag, input logic [12:0] v);
    exp_t x;
    x.cyc = c;
    x.tag = tag;
    x.val = v;
    sb.push_back(x);
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic d, input logic [7:0] v, output int edge_n);
    cmd_dir   = d;
    cmd_duty  = v;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    edge_n    = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expectations, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_duty = 8'd0; estop = 1'b0;
    repeat (3) @(negedge clk);
    cmp("reset_state", outs, pk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    rst = 1'b0;
    @(negedge clk);
    #1;
    cmp("post_reset_idle", outs, pk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));

    // Direction change at zero duty: straight into dead time, then flip.
    send(1'b1, 8'd0, n);
    expect_at(n,      "dirset_busy",  pk(8'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(n + 8,  "dirset_hold",  pk(8'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(n + 9,  "dirset_flip",  pk(8'd0, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 13, "dirset_idle",  pk(8'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    drain();

    send(1'b1, 8'd64, n);
    expect_at(n,      "up_busy",  pk(8'd0,  1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 3,  "up_wait",  pk(8'd0,  1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 4,  "up_16",    pk(8'd16, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 8,  "up_32",    pk(8'd32, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 12, "up_48",    pk(8'd48, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 15, "up_48_hold", pk(8'd48, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 16, "up_64_idle", pk(8'd64, 1'b1, 1'b0, 1'b1, 1'b1));
    drain();

    send(1'b1, 8'd0, n);
    expect_at(n + 4,  "down_48",   pk(8'd48, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 16, "down_0_idle", pk(8'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    drain();

    send(1'b1, 8'd40, n);
    expect_at(n + 4,  "sat40_16",  pk(8'd16, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 8,  "sat40_32",  pk(8'd32, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 11, "sat40_hold", pk(8'd32, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 12, "sat40_40",  pk(8'd40, 1'b1, 1'b0, 1'b1, 1'b1));
    drain();

    // Retarget to 255 mid-ramp; the last step clamps at the top without wrapping.
    send(1'b1, 8'd250, n);
    expect_at(n + 4,  "sat255_56", pk(8'd56, 1'b1, 1'b1, 1'b0, 1'b1));
    goto_cycle(n + 5);
    send(1'b1, 8'd255, m);
    expect_at(m,      "sat255_retarget", pk(8'd56,  1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 8,  "sat255_72",       pk(8'd72,  1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 52, "sat255_248",      pk(8'd248, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 55, "sat255_hold",     pk(8'd248, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 56, "sat255_top",      pk(8'd255, 1'b1, 1'b0, 1'b1, 1'b1));
    drain();

    send(1'b1, 8'd64, n);
    expect_at(n + 4,  "dn64_239",  pk(8'd239, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 44, "dn64_79",   pk(8'd79,  1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 48, "dn64_clamp", pk(8'd64, 1'b1, 1'b0, 1'b1, 1'b1));
    drain();

    send(1'b0, 8'd32, n);
    expect_at(n + 4,  "rev_48",      pk(8'd48, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 8,  "rev_32",      pk(8'd32, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 12, "rev_16",      pk(8'd16, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 16, "rev_zero",    pk(8'd0,  1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 23, "rev_dead_end", pk(8'd0, 1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 24, "rev_flip",    pk(8'd0,  1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(n + 27, "rev_wait",    pk(8'd0,  1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(n + 28, "rev_up16",    pk(8'd16, 1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(n + 32, "rev_up32_idle", pk(8'd32, 1'b0, 1'b0, 1'b1, 1'b1));
    drain();

    send(1'b0, 8'd128, n);
    expect_at(n + 4, "retgt_48", pk(8'd48, 1'b0, 1'b1, 1'b0, 1'b1));
    goto_cycle(n + 5);
    send(1'b0, 8'd32, m);
    expect_at(m,     "retgt_accept", pk(8'd48, 1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(n + 7, "retgt_hold",   pk(8'd48, 1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(n + 8, "retgt_32_idle", pk(8'd32, 1'b0, 1'b0, 1'b1, 1'b1));
    drain();

    send(1'b0, 8'd96, n);
    expect_at(n + 4, "estop_pre48", pk(8'd48, 1'b0, 1'b1, 1'b0, 1'b1));
    goto_cycle(n + 5);
    estop = 1'b1;
    expect_at(n + 6,  "estop_zero",    pk(8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_at(n + 7,  "estop_ignore",  pk(8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_at(n + 8,  "estop_held",    pk(8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_at(n + 9,  "estop_release", pk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    expect_at(n + 14, "estop_settled", pk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    goto_cycle(n + 6);
    cmd_dir = 1'b1; cmd_duty = 8'd200; cmd_valid = 1'b1;
    goto_cycle(n + 7);
    cmd_valid = 1'b0;
    goto_cycle(n + 8);
    estop = 1'b0;
    drain();

    // Asynchronous reset in the middle of a ramp, checked between edges.
    send(1'b1, 8'd64, n);
    expect_at(n,      "rst_run_busy", pk(8'd0,  1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(n + 9,  "rst_run_flip", pk(8'd0,  1'b1, 1'b1, 1'b0, 1'b1));
    expect_at(n + 13, "rst_run_16",   pk(8'd16, 1'b1, 1'b1, 1'b0, 1'b1));
    goto_cycle(n + 14);
    #1;
    rst = 1'b1;
    #1;
    cmp("async_reset", outs, pk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    cmp("after_reset_idle", outs, pk(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
